// File: rtl/decoder_seq.sv
// Multi-cycle 6502 decoder for the ALU group (cc=01) plus NOP: latches the opcode
// at T0, then steps a T-state counter and drives per-cycle bus/PC/register/ALU controls.
module decoder_seq #(
  parameter int TW               = 3,
  parameter int ALU_W            = 4,
  parameter int EXTRA_PAGE_CYCLE = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  input  logic             ready,
  input  logic             page_cross,
  input  logic [7:0]       instruction,
  output logic             w_rd,
  output logic             pc_data,
  output logic             increment,
  output logic             lower_byte,
  output logic             acc_con,
  output logic             status_con,
  output logic [ALU_W-1:0] alu_op,
  output logic [1:0]       operand_mux_con,
  output logic             sync,
  output logic             busy,
  output logic             last_cycle,
  output logic             illegal
);

  typedef enum logic {S_FETCH, S_EXEC} state_t;

  localparam logic [TW-1:0] T0    = '0;
  localparam logic [TW-1:0] T1    = TW'(1);
  localparam logic [TW-1:0] T2    = TW'(2);
  localparam logic [TW-1:0] T3    = TW'(3);
  localparam logic [TW-1:0] T4    = TW'(4);
  localparam logic [TW-1:0] T_MAX = '1;

  state_t           state, state_nx;
  logic [TW-1:0]    t, t_nx;
  logic [7:0]       opcode_r, opcode_nx;
  logic             ext_r, ext_nx;
  logic [ALU_W-1:0] alu_r;

  logic [2:0]  aaa, bbb;
  logic        is_nop, is_alu, is_ill, is_sta, is_cmp;
  logic        mode_abs, mode_idx, mode_imm;
  logic        at_sample, page_now, sta_ext;
  logic [TW:0] base_n, n_eff, t_ext;
  logic        in_exec, is_last, guard, fire, operand_cyc;

  assign aaa      = opcode_r[7:5];
  assign bbb      = opcode_r[4:2];
  assign is_nop   = (opcode_r == 8'hEA);
  assign is_alu   = (opcode_r[1:0] == 2'b01) && (opcode_r != 8'h89);
  assign is_ill   = !is_nop && !is_alu;
  assign is_sta   = (aaa == 3'b100);
  assign is_cmp   = (aaa == 3'b110);
  assign mode_abs = (bbb == 3'b011) || (bbb == 3'b110) || (bbb == 3'b111);
  assign mode_idx = (bbb == 3'b100) || (bbb == 3'b110) || (bbb == 3'b111);
  assign mode_imm = (bbb == 3'b010);
  assign in_exec  = (state == S_EXEC);

  always_comb begin
    base_n = (TW+1)'(2);
    if (is_alu) begin
      case (bbb)
        3'b000:  base_n = (TW+1)'(6);
        3'b001:  base_n = (TW+1)'(3);
        3'b010:  base_n = (TW+1)'(2);
        3'b100:  base_n = (TW+1)'(5);
        default: base_n = (TW+1)'(4);
      endcase
    end
  end

  // The page-cross extension is decided combinationally in the sampling cycle
  // (which may be the base last cycle) and remembered in ext_r afterwards.
  assign at_sample = in_exec && is_alu && mode_idx && (t == ((bbb == 3'b100) ? T4 : T3));
  assign page_now  = (EXTRA_PAGE_CYCLE != 0) && page_cross && at_sample && !is_sta;
  assign sta_ext   = is_alu && mode_idx && is_sta;
  assign n_eff     = base_n + (TW+1)'(sta_ext) + (TW+1)'(ext_r | page_now);
  assign t_ext     = {1'b0, t} + (TW+1)'(1);
  assign is_last   = in_exec && (t_ext == n_eff);
  assign guard     = in_exec && !is_last && (t == T_MAX);
  assign fire      = !rst && !flush && ready;
  assign operand_cyc = in_exec && is_alu && ((t == T1) || ((t == T2) && mode_abs));

  // NOTE: every output gets a default before any branch so no latch is inferred.
  always_comb begin
    sync            = (state == S_FETCH);
    busy            = (state != S_FETCH);
    w_rd            = 1'b1;
    pc_data         = 1'b1;
    increment       = 1'b0;
    lower_byte      = 1'b0;
    acc_con         = 1'b0;
    status_con      = 1'b0;
    alu_op          = alu_r;
    operand_mux_con = 2'b11;
    last_cycle      = 1'b0;
    illegal         = 1'b0;
    if (in_exec && !rst) pc_data = operand_cyc || !is_alu;
    if (fire) begin
      if (!in_exec) begin
        increment = 1'b1;
      end else begin
        increment  = operand_cyc;
        lower_byte = operand_cyc && mode_abs && (t == T1);
        illegal    = guard;
        if (is_last) begin
          last_cycle = 1'b1;
          illegal    = is_ill;
          if (is_alu) begin
            alu_op          = ALU_W'(aaa);
            operand_mux_con = mode_imm ? 2'b01 : 2'b00;
            acc_con         = !is_sta && !is_cmp;
            status_con      = !is_sta;
            w_rd            = !is_sta;
          end
        end
      end
    end
  end

  always_comb begin
    state_nx  = state;
    t_nx      = t;
    opcode_nx = opcode_r;
    ext_nx    = ext_r;
    if (flush) begin
      state_nx = S_FETCH;
      t_nx     = T0;
      ext_nx   = 1'b0;
    end else if (ready) begin
      if (!in_exec) begin
        opcode_nx = instruction;
        t_nx      = T1;
        state_nx  = S_EXEC;
      end else if (is_last || guard) begin
        state_nx = S_FETCH;
        t_nx     = T0;
        ext_nx   = 1'b0;
      end else begin
        t_nx = t + T1;
        if (page_now) ext_nx = 1'b1;
      end
    end
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update together.
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= S_FETCH;
      t        <= T0;
      opcode_r <= 8'hEA;
      ext_r    <= 1'b0;
      alu_r    <= '0;
    end else begin
      state    <= state_nx;
      t        <= t_nx;
      opcode_r <= opcode_nx;
      ext_r    <= ext_nx;
      alu_r    <= alu_op;
    end
  end

endmodule

// File: tb/tb_decoder_seq.sv
// Scoreboard bench for decoder_seq: the stimulus pushes hand-computed per-cycle
// output vectors; a negedge monitor pops and compares them.
module tb_decoder_seq;

  logic       clk = 1'b0;
  logic       rst = 1'b1, flush = 1'b0, ready = 1'b1, page_cross = 1'b0;
  logic [7:0] instruction = 8'h00;
  logic       w_rd, pc_data, increment, lower_byte, acc_con, status_con;
  logic [3:0] alu_op;
  logic [1:0] operand_mux_con;
  logic       sync, busy, last_cycle, illegal;

  decoder_seq #(.TW(3), .ALU_W(4), .EXTRA_PAGE_CYCLE(1)) dut (
    .clk(clk), .rst(rst), .flush(flush), .ready(ready), .page_cross(page_cross),
    .instruction(instruction), .w_rd(w_rd), .pc_data(pc_data), .increment(increment),
    .lower_byte(lower_byte), .acc_con(acc_con), .status_con(status_con), .alu_op(alu_op),
    .operand_mux_con(operand_mux_con), .sync(sync), .busy(busy),
    .last_cycle(last_cycle), .illegal(illegal)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [15:0] exp;
    string       name;
  } item_t;

  item_t sb_q[$];
  int    errors = 0;
  int    checks = 0;

  // Vector order: sync busy last w_rd pc_data inc lower acc status illegal alu[3:0] omc[1:0]
  function automatic logic [15:0] mk(logic s, logic b, logic l, logic w, logic p, logic i,
                                     logic lb, logic a, logic st, logic il,
                                     logic [3:0] alu, logic [1:0] omc);
    return {s, b, l, w, p, i, lb, a, st, il, alu, omc};
  endfunction

  function automatic logic [15:0] fetch_e(logic [3:0] alu);
    return mk(1, 0, 0, 1, 1, 1, 0, 0, 0, 0, alu, 2'b11);
  endfunction
  function automatic logic [15:0] oper_e(logic lb, logic [3:0] alu);
    return mk(0, 1, 0, 1, 1, 1, lb, 0, 0, 0, alu, 2'b11);
  endfunction
  function automatic logic [15:0] data_e(logic [3:0] alu);
    return mk(0, 1, 0, 1, 0, 0, 0, 0, 0, 0, alu, 2'b11);
  endfunction
  function automatic logic [15:0] last_e(logic w, logic a, logic st, logic [3:0] alu);
    return mk(0, 1, 1, w, 0, 0, 0, a, st, 0, alu, 2'b00);
  endfunction

  task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %b expected %b (sync busy last w_rd pc inc lb acc st ill alu omc)",
               name, act, exp);
    end
  endtask

  initial begin : monitor
    item_t it;
    forever begin
      @(negedge clk);
      if (sb_q.size() > 0) begin
        it = sb_q.pop_front();
        check(it.name, {sync, busy, last_cycle, w_rd, pc_data, increment, lower_byte,
                        acc_con, status_con, illegal, alu_op, operand_mux_con}, it.exp);
      end
    end
  end

  task automatic step(input logic r, input logic fl, input logic rdy, input logic pc,
                      input logic [7:0] ins, input logic [15:0] e, input string nm,
                      input bit chk = 1'b1);
    item_t it;
    @(posedge clk);
    #1;
    rst = r; flush = fl; ready = rdy; page_cross = pc; instruction = ins;
    if (chk) begin
      it.exp  = e;
      it.name = nm;
      sb_q.push_back(it);
    end
  endtask

  initial begin
    step(1, 0, 1, 0, 8'h00, '0, "rst_a", 1'b0);
    step(1, 0, 1, 0, 8'h00, mk(1, 0, 0, 1, 1, 0, 0, 0, 0, 0, 4'd0, 2'b11), "reset_state");

    // ADC #imm
    step(0, 0, 1, 0, 8'h69, fetch_e(4'd0), "adc_imm_t0");
    step(0, 0, 1, 0, 8'h00, mk(0, 1, 1, 1, 1, 1, 0, 1, 1, 0, 4'd3, 2'b01), "adc_imm_t1");
    // ADC abs
    step(0, 0, 1, 0, 8'h6D, fetch_e(4'd3), "adc_abs_t0");
    step(0, 0, 1, 0, 8'h00, oper_e(1, 4'd3), "adc_abs_t1");
    step(0, 0, 1, 0, 8'h00, oper_e(0, 4'd3), "adc_abs_t2");
    step(0, 0, 1, 0, 8'h00, last_e(1, 1, 1, 4'd3), "adc_abs_t3");
    // ADC abs,X with page cross
    step(0, 0, 1, 0, 8'h7D, fetch_e(4'd3), "adc_absx_pc_t0");
    step(0, 0, 1, 0, 8'h00, oper_e(1, 4'd3), "adc_absx_pc_t1");
    step(0, 0, 1, 0, 8'h00, oper_e(0, 4'd3), "adc_absx_pc_t2");
    step(0, 0, 1, 1, 8'h00, data_e(4'd3), "adc_absx_pc_t3");
    step(0, 0, 1, 0, 8'h00, last_e(1, 1, 1, 4'd3), "adc_absx_pc_t4");
    // ADC abs,X without page cross
    step(0, 0, 1, 0, 8'h7D, fetch_e(4'd3), "adc_absx_t0");
    step(0, 0, 1, 0, 8'h00, oper_e(1, 4'd3), "adc_absx_t1");
    step(0, 0, 1, 0, 8'h00, oper_e(0, 4'd3), "adc_absx_t2");
    step(0, 0, 1, 0, 8'h00, last_e(1, 1, 1, 4'd3), "adc_absx_t3");
    // STA abs
    step(0, 0, 1, 0, 8'h8D, fetch_e(4'd3), "sta_abs_t0");
    step(0, 0, 1, 0, 8'h00, oper_e(1, 4'd3), "sta_abs_t1");
    step(0, 0, 1, 0, 8'h00, oper_e(0, 4'd3), "sta_abs_t2");
    step(0, 0, 1, 0, 8'h00, last_e(0, 0, 0, 4'd4), "sta_abs_t3");
    // STA abs,X always takes the extra cycle
    step(0, 0, 1, 0, 8'h9D, fetch_e(4'd4), "sta_absx_t0");
    step(0, 0, 1, 0, 8'h00, oper_e(1, 4'd4), "sta_absx_t1");
    step(0, 0, 1, 0, 8'h00, oper_e(0, 4'd4), "sta_absx_t2");
    step(0, 0, 1, 0, 8'h00, data_e(4'd4), "sta_absx_t3");
    step(0, 0, 1, 0, 8'h00, last_e(0, 0, 0, 4'd4), "sta_absx_t4");
    // ADC (zp),Y stalled three cycles at T2: 8 clocks total
    step(0, 0, 1, 0, 8'h71, fetch_e(4'd4), "adc_izy_st_t0");
    step(0, 0, 1, 0, 8'h00, oper_e(0, 4'd4), "adc_izy_st_t1");
    for (int i = 0; i < 3; i++)
      step(0, 0, 0, 0, 8'h00, data_e(4'd4), $sformatf("adc_izy_stall%0d", i));
    step(0, 0, 1, 0, 8'h00, data_e(4'd4), "adc_izy_st_t2");
    step(0, 0, 1, 0, 8'h00, data_e(4'd4), "adc_izy_st_t3");
    step(0, 0, 1, 0, 8'h00, last_e(1, 1, 1, 4'd3), "adc_izy_st_t4");
    // ADC (zp),Y with page cross sampled at T4
    step(0, 0, 1, 0, 8'h71, fetch_e(4'd3), "adc_izy_pc_t0");
    step(0, 0, 1, 0, 8'h00, oper_e(0, 4'd3), "adc_izy_pc_t1");
    step(0, 0, 1, 0, 8'h00, data_e(4'd3), "adc_izy_pc_t2");
    step(0, 0, 1, 0, 8'h00, data_e(4'd3), "adc_izy_pc_t3");
    step(0, 0, 1, 1, 8'h00, data_e(4'd3), "adc_izy_pc_t4");
    step(0, 0, 1, 0, 8'h00, last_e(1, 1, 1, 4'd3), "adc_izy_pc_t5");
    // ADC (zp,X) flushed at T3, then a flush during T0 discards 0x29
    step(0, 0, 1, 0, 8'h61, fetch_e(4'd3), "adc_izx_t0");
    step(0, 0, 1, 0, 8'h00, oper_e(0, 4'd3), "adc_izx_t1");
    step(0, 0, 1, 0, 8'h00, data_e(4'd3), "adc_izx_t2");
    step(0, 1, 1, 0, 8'h00, data_e(4'd3), "adc_izx_flush_t3");
    step(0, 1, 1, 0, 8'h29, mk(1, 0, 0, 1, 1, 0, 0, 0, 0, 0, 4'd3, 2'b11), "flush_in_t0");
    // Illegal opcodes and NOP
    step(0, 0, 1, 0, 8'h02, fetch_e(4'd3), "ill_02_t0");
    step(0, 0, 1, 0, 8'h00, mk(0, 1, 1, 1, 1, 0, 0, 0, 0, 1, 4'd3, 2'b11), "ill_02_t1");
    step(0, 0, 1, 0, 8'h89, fetch_e(4'd3), "ill_89_t0");
    step(0, 0, 1, 0, 8'h00, mk(0, 1, 1, 1, 1, 0, 0, 0, 0, 1, 4'd3, 2'b11), "ill_89_t1");
    step(0, 0, 1, 0, 8'hEA, fetch_e(4'd3), "nop_t0");
    step(0, 0, 1, 0, 8'h00, mk(0, 1, 1, 1, 1, 0, 0, 0, 0, 0, 4'd3, 2'b11), "nop_t1");
    // CMP abs: status only
    step(0, 0, 1, 0, 8'hCD, fetch_e(4'd3), "cmp_abs_t0");
    step(0, 0, 1, 0, 8'h00, oper_e(1, 4'd3), "cmp_abs_t1");
    step(0, 0, 1, 0, 8'h00, oper_e(0, 4'd3), "cmp_abs_t2");
    step(0, 0, 1, 0, 8'h00, last_e(1, 0, 1, 4'd6), "cmp_abs_t3");
    // Reset mid-instruction, then resume
    step(0, 0, 1, 0, 8'h6D, fetch_e(4'd6), "rst_mid_t0");
    step(0, 0, 1, 0, 8'h00, oper_e(1, 4'd6), "rst_mid_t1");
    step(1, 0, 1, 0, 8'h00, mk(0, 1, 0, 1, 1, 0, 0, 0, 0, 0, 4'd6, 2'b11), "rst_mid_t2");
    step(0, 0, 1, 0, 8'h69, fetch_e(4'd0), "post_rst_t0");
    step(0, 0, 1, 0, 8'h00, mk(0, 1, 1, 1, 1, 1, 0, 1, 1, 0, 4'd3, 2'b01), "post_rst_t1");

    @(posedge clk);
    #1;
    checks++;
    if (sb_q.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain: got %0d pending expected 0", sb_q.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
